load_unit: RTL and testbench

LOAD_UNIT -- requirements
Module: load_unit

---
 rtl/load_unit.sv | 164 ++++++++++++++++
 tb/tb_load_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// load_unit: RISC-V style load unit (LB/LH/LW/LBU/LHU).
// Accepts one load at a time and issues a word-aligned memory read.
// Extracts and extends the addressed byte or half from the returned word.
// Writes the result back to the register file; a missing ack within
// TIMEOUT_CYCLES, or an illegal func3, produces a one-cycle load_fault pulse.
// Optional build macro: LOAD_MISALIGN_TRAP_EN -- misaligned LH/LHU/LW fault
// instead of silently using the aligned lanes.
module load_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] base_addr,
    input  logic [31:0] imm,
    input  logic [2:0]  func3,
    input  logic [4:0]  rd_in,
    output logic        mem_read_req,
    output logic [31:0] mem_read_address,
    input  logic        mem_read_ack,
    input  logic [31:0] mem_read_data,
    output logic        reg_write,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic        load_fault
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WB    = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [31:0]   addr_reg, addr_next;
    logic [2:0]    func3_reg, func3_next;
    logic [4:0]    rd_reg, rd_next;
    logic [31:0]   data_reg, data_next;
    logic [TW-1:0] timer_reg, timer_next;

    logic [31:0]   eff_addr;
    logic          illegal_func3;
    logic          misaligned;
    logic [31:0]   extracted;

    assign eff_addr = base_addr + imm;

    // func3 encodings 011, 110 and 111 are not loads this unit supports
    assign illegal_func3 = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);

`ifdef LOAD_MISALIGN_TRAP_EN
    // Halves must be 2-byte aligned (func3 x01), words 4-byte aligned
    assign misaligned = ((func3[1:0] == 2'b01) && eff_addr[0])
                     || ((func3 == 3'b010) && (eff_addr[1:0] != 2'b00));
`else
    // Low address bits below the access size are simply ignored
    assign misaligned = 1'b0;
`endif

    // Little-endian byte and half lanes of the captured memory word
    logic [7:0]  byte_lane [4];
    logic [15:0] half_lane [2];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign byte_lane[gi] = data_reg[8*gi +: 8];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
            assign half_lane[gi] = data_reg[16*gi +: 16];
        end
    endgenerate

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = byte_lane[addr_reg[1:0]];
    assign sel_half = half_lane[addr_reg[1]];

    // Select the addressed lane and sign- or zero-extend it by load type
    always_comb begin
        extracted = data_reg;
        case (func3_reg)
            3'b000:  extracted = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  extracted = {24'h0, sel_byte};
            3'b001:  extracted = {{16{sel_half[15]}}, sel_half};
            3'b101:  extracted = {16'h0, sel_half};
            default: extracted = data_reg;
        endcase
    end

    // State register and latched request fields
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            func3_reg <= '0;
            rd_reg    <= '0;
            data_reg  <= '0;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            func3_reg <= func3_next;
            rd_reg    <= rd_next;
            data_reg  <= data_next;
            timer_reg <= timer_next;
        end
    end

    // Next-state logic: accept, wait for ack or timeout, then writeback or fault
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        func3_next = func3_reg;
        rd_next    = rd_reg;
        data_next  = data_reg;
        timer_next = timer_reg;
        case (state_reg)
            IDLE: begin
                if (load_valid) begin
                    addr_next  = eff_addr;
                    func3_next = func3;
                    rd_next    = rd_in;
                    timer_next = '0;
                    state_next = (illegal_func3 || misaligned) ? FAULT : REQ;
                end
            end
            REQ: begin
                // An ack in the final allowed cycle still completes the load
                if (mem_read_ack) begin
                    data_next  = mem_read_data;
                    state_next = WB;
                end else if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_next = FAULT;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            WB: begin
                timer_next = '0;
                state_next = IDLE;
            end
            FAULT: begin
                timer_next = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode the state; reset forces every strobe and writeback field low
    assign load_ready       = (state_reg == IDLE) && !reset;
    assign mem_read_req     = (state_reg == REQ) && !reset;
    assign mem_read_address = {addr_reg[31:2], 2'b00};
    assign reg_write        = (state_reg == WB) && (rd_reg != 5'd0) && !reset;
    assign write_reg        = ((state_reg == WB) && !reset) ? rd_reg : 5'd0;
    assign write_data       = ((state_reg == WB) && !reset) ? extracted : 32'd0;
    assign load_fault       = (state_reg == FAULT) && !reset;

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed self-checking bench for load_unit.
// Honors LOAD_MISALIGN_TRAP_EN for the misaligned-access expectations.
module tb_load_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] base_addr;
    logic [31:0] imm;
    logic [2:0]  func3;
    logic [4:0]  rd_in;
    logic        mem_read_req;
    logic [31:0] mem_read_address;
    logic        mem_read_ack;
    logic [31:0] mem_read_data;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        load_fault;

    int vectors = 0;
    int miscompares = 0;

    // Observations gathered by run_load
    logic        r_saw_req;
    logic [31:0] r_req_addr;
    logic        r_addr_changed;
    int          r_req_cycles;
    int          r_first_req;
    logic        r_saw_wb;
    logic [4:0]  r_wreg;
    logic [31:0] r_wdata;
    int          r_wb_idx;
    int          r_ack_idx;
    int          r_fault_cnt;
    logic        r_done;

    load_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clock            (clock),
        .reset            (reset),
        .load_valid       (load_valid),
        .load_ready       (load_ready),
        .base_addr        (base_addr),
        .imm              (imm),
        .func3            (func3),
        .rd_in            (rd_in),
        .mem_read_req     (mem_read_req),
        .mem_read_address (mem_read_address),
        .mem_read_ack     (mem_read_ack),
        .mem_read_data    (mem_read_data),
        .reg_write        (reg_write),
        .write_reg        (write_reg),
        .write_data       (write_data),
        .load_fault       (load_fault)
    );

    always #5 clock = ~clock;

    // Issue one load from IDLE and record what happens until load_ready returns.
    // ack_at: index of the REQ cycle in which ack is driven (-1 = never).
    task automatic run_load(input logic [31:0] b, input logic [31:0] i, input logic [2:0] f,
                            input logic [4:0] rd, input logic [31:0] data, input int ack_at);
        r_saw_req = 0; r_req_addr = '0; r_addr_changed = 0; r_req_cycles = 0;
        r_first_req = -1; r_saw_wb = 0; r_wreg = '0; r_wdata = '0;
        r_wb_idx = -1; r_ack_idx = -1; r_fault_cnt = 0; r_done = 0;
        base_addr = b; imm = i; func3 = f; rd_in = rd; load_valid = 1'b1;
        @(posedge clock); #1;
        load_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            mem_read_ack  = 1'b0;
            mem_read_data = 32'hBAD0BAD0;
            if (load_ready) begin
                r_done = 1;
                break;
            end
            if (mem_read_req) begin
                if (!r_saw_req) begin
                    r_first_req = k;
                    r_req_addr  = mem_read_address;
                end else if (mem_read_address !== r_req_addr) begin
                    r_addr_changed = 1;
                end
                r_saw_req = 1;
                if (r_req_cycles == ack_at) begin
                    mem_read_ack  = 1'b1;
                    mem_read_data = data;
                    r_ack_idx     = k;
                end
                r_req_cycles++;
            end
            if (reg_write) begin
                r_saw_wb = 1; r_wreg = write_reg; r_wdata = write_data; r_wb_idx = k;
            end
            if (load_fault) r_fault_cnt++;
            @(posedge clock); #1;
        end
        mem_read_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; load_valid = 1'b0; mem_read_ack = 1'b0; mem_read_data = '0;
        base_addr = '0; imm = '0; func3 = '0; rd_in = '0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        vectors++;
        if (load_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b expected 0", load_ready); end
        vectors++;
        if ({mem_read_req, reg_write, load_fault} !== 3'b000) begin
            miscompares++; $display("FAIL reset_strobes: got %b expected 000", {mem_read_req, reg_write, load_fault});
        end
        vectors++;
        if ({write_reg, write_data} !== 37'd0) begin
            miscompares++; $display("FAIL reset_wb_fields: got reg %0d data %h expected 0/0", write_reg, write_data);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (load_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready: got %b expected 1", load_ready); end
        @(posedge clock); #1;
    endtask

    task automatic test_lw();
        run_load(32'h100, 32'h4, 3'b010, 5'd5, 32'hDEADBEEF, 2);
        vectors++;
        if (!r_done) begin miscompares++; $display("FAIL lw_done: load never returned to IDLE"); end
        vectors++;
        if (r_req_addr !== 32'h104) begin miscompares++; $display("FAIL lw_addr: got %h expected 00000104", r_req_addr); end
        vectors++;
        if (r_first_req !== 0) begin miscompares++; $display("FAIL lw_req_latency: got cycle %0d expected 0", r_first_req); end
        vectors++;
        if (r_addr_changed !== 1'b0) begin miscompares++; $display("FAIL lw_addr_stable: address changed during REQ"); end
        vectors++;
        if (!r_saw_wb || r_wreg !== 5'd5 || r_wdata !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL lw_wb: got we %b reg %0d data %h expected 1/5/deadbeef", r_saw_wb, r_wreg, r_wdata);
        end
        vectors++;
        if (r_wb_idx !== r_ack_idx + 1) begin
            miscompares++; $display("FAIL lw_wb_latency: got wb cycle %0d expected %0d", r_wb_idx, r_ack_idx + 1);
        end
        vectors++;
        if (r_fault_cnt !== 0) begin miscompares++; $display("FAIL lw_no_fault: got %0d fault cycles expected 0", r_fault_cnt); end
    endtask

    task automatic test_byte_loads();
        run_load(32'h100, 32'h3, 3'b000, 5'd1, 32'h80FF0000, 0);
        vectors++;
        if (r_req_addr !== 32'h100 || r_wdata !== 32'hFFFFFF80) begin
            miscompares++; $display("FAIL lb_103: got addr %h data %h expected 00000100/ffffff80", r_req_addr, r_wdata);
        end
        run_load(32'h100, 32'h3, 3'b100, 5'd2, 32'h80FF0000, 0);
        vectors++;
        if (r_wdata !== 32'h00000080) begin miscompares++; $display("FAIL lbu_103: got %h expected 00000080", r_wdata); end
        // Negative offset exercises wraparound of base+imm
        run_load(32'h104, 32'hFFFFFFFD, 3'b000, 5'd3, 32'h12345678, 0);
        vectors++;
        if (r_req_addr !== 32'h100 || r_wdata !== 32'h00000056) begin
            miscompares++; $display("FAIL lb_neg_imm: got addr %h data %h expected 00000100/00000056", r_req_addr, r_wdata);
        end
    endtask

    task automatic test_half_loads();
        run_load(32'h100, 32'h2, 3'b001, 5'd4, 32'h80011234, 1);
        vectors++;
        if (r_wdata !== 32'hFFFF8001) begin miscompares++; $display("FAIL lh_102: got %h expected ffff8001", r_wdata); end
        run_load(32'h100, 32'h0, 3'b101, 5'd4, 32'h80011234, 1);
        vectors++;
        if (r_wdata !== 32'h00001234) begin miscompares++; $display("FAIL lhu_100: got %h expected 00001234", r_wdata); end
    endtask

    task automatic test_timeout();
        run_load(32'h200, 32'h0, 3'b010, 5'd6, 32'h0, -1);
        vectors++;
        if (r_fault_cnt !== 1 || r_saw_wb !== 1'b0) begin
            miscompares++; $display("FAIL timeout_fault: got faults %0d we %b expected 1/0", r_fault_cnt, r_saw_wb);
        end
        vectors++;
        if (r_req_cycles !== 16) begin miscompares++; $display("FAIL timeout_len: got %0d REQ cycles expected 16", r_req_cycles); end
        run_load(32'h200, 32'h0, 3'b010, 5'd6, 32'hCAFEF00D, 15);
        vectors++;
        if (r_fault_cnt !== 0 || !r_saw_wb || r_wdata !== 32'hCAFEF00D) begin
            miscompares++; $display("FAIL ack_at_16: got faults %0d we %b data %h expected 0/1/cafef00d", r_fault_cnt, r_saw_wb, r_wdata);
        end
    endtask

    task automatic test_misalign();
        run_load(32'h100, 32'h2, 3'b010, 5'd8, 32'h11223344, 0);
`ifdef LOAD_MISALIGN_TRAP_EN
        vectors++;
        if (r_saw_req !== 1'b0 || r_fault_cnt !== 1 || r_saw_wb !== 1'b0) begin
            miscompares++; $display("FAIL lw_misalign: got req %b faults %0d we %b expected 0/1/0", r_saw_req, r_fault_cnt, r_saw_wb);
        end
        run_load(32'h100, 32'h1, 3'b001, 5'd8, 32'h11223344, 0);
        vectors++;
        if (r_saw_req !== 1'b0 || r_fault_cnt !== 1) begin
            miscompares++; $display("FAIL lh_misalign: got req %b faults %0d expected 0/1", r_saw_req, r_fault_cnt);
        end
`else
        vectors++;
        if (r_req_addr !== 32'h100 || r_wdata !== 32'h11223344 || r_fault_cnt !== 0) begin
            miscompares++; $display("FAIL lw_misalign: got addr %h data %h faults %0d expected 00000100/11223344/0", r_req_addr, r_wdata, r_fault_cnt);
        end
        run_load(32'h100, 32'h1, 3'b001, 5'd8, 32'h1122F344, 0);
        vectors++;
        if (r_wdata !== 32'hFFFFF344 || r_fault_cnt !== 0) begin
            miscompares++; $display("FAIL lh_misalign: got data %h faults %0d expected fffff344/0", r_wdata, r_fault_cnt);
        end
`endif
        run_load(32'h100, 32'h0, 3'b011, 5'd8, 32'h0, 0);
        vectors++;
        if (r_saw_req !== 1'b0 || r_fault_cnt !== 1 || r_saw_wb !== 1'b0) begin
            miscompares++; $display("FAIL func3_011: got req %b faults %0d we %b expected 0/1/0", r_saw_req, r_fault_cnt, r_saw_wb);
        end
        run_load(32'h100, 32'h0, 3'b111, 5'd8, 32'h0, 0);
        vectors++;
        if (r_saw_req !== 1'b0 || r_fault_cnt !== 1) begin
            miscompares++; $display("FAIL func3_111: got req %b faults %0d expected 0/1", r_saw_req, r_fault_cnt);
        end
    endtask

    task automatic test_reset_mid();
        base_addr = 32'h300; imm = '0; func3 = 3'b010; rd_in = 5'd7; load_valid = 1'b1;
        @(posedge clock); #1;
        load_valid = 1'b0;
        vectors++;
        if (mem_read_req !== 1'b1) begin miscompares++; $display("FAIL midreset_req: got %b expected 1", mem_read_req); end
        reset = 1'b1;
        #1;
        vectors++;
        if (mem_read_req !== 1'b0 || load_ready !== 1'b0) begin
            miscompares++; $display("FAIL midreset_hold: got req %b ready %b expected 0/0", mem_read_req, load_ready);
        end
        @(posedge clock); #1;
        reset = 1'b0; mem_read_ack = 1'b1; mem_read_data = 32'h11111111;
        #1;
        vectors++;
        if (load_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_ready: got %b expected 1", load_ready); end
        @(posedge clock); #1;
        mem_read_ack = 1'b0;
        vectors++;
        if (reg_write !== 1'b0 || mem_read_req !== 1'b0 || load_ready !== 1'b1) begin
            miscompares++; $display("FAIL late_ack: got we %b req %b ready %b expected 0/0/1", reg_write, mem_read_req, load_ready);
        end
        run_load(32'h100, 32'h0, 3'b010, 5'd0, 32'h55AA55AA, 0);
        vectors++;
        if (r_saw_req !== 1'b1 || r_saw_wb !== 1'b0 || r_fault_cnt !== 0 || !r_done) begin
            miscompares++; $display("FAIL rd0: got req %b we %b faults %0d expected 1/0/0", r_saw_req, r_saw_wb, r_fault_cnt);
        end
    endtask

    task automatic test_ack_outside_req();
        mem_read_ack = 1'b1; mem_read_data = 32'h77777777;
        for (int k = 0; k < 2; k++) begin
            @(posedge clock); #1;
            vectors++;
            if (reg_write !== 1'b0 || mem_read_req !== 1'b0 || load_ready !== 1'b1) begin
                miscompares++; $display("FAIL idle_ack: got we %b req %b ready %b expected 0/0/1", reg_write, mem_read_req, load_ready);
            end
        end
        mem_read_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        base_addr = 32'h400; imm = '0; func3 = 3'b010; rd_in = 5'd9; load_valid = 1'b1;
        @(posedge clock); #1;
        vectors++;
        if (load_ready !== 1'b0 || mem_read_req !== 1'b1) begin
            miscompares++; $display("FAIL b2b_req1: got ready %b req %b expected 0/1", load_ready, mem_read_req);
        end
        mem_read_ack = 1'b1; mem_read_data = 32'hA5A5A5A5;
        @(posedge clock); #1;
        mem_read_ack = 1'b0;
        vectors++;
        if (reg_write !== 1'b1 || write_data !== 32'hA5A5A5A5 || load_ready !== 1'b0) begin
            miscompares++; $display("FAIL b2b_wb1: got we %b data %h ready %b expected 1/a5a5a5a5/0", reg_write, write_data, load_ready);
        end
        @(posedge clock); #1;
        vectors++;
        if (load_ready !== 1'b1 || mem_read_req !== 1'b0) begin
            miscompares++; $display("FAIL b2b_idle: got ready %b req %b expected 1/0", load_ready, mem_read_req);
        end
        @(posedge clock); #1;
        load_valid = 1'b0;
        vectors++;
        if (mem_read_req !== 1'b1) begin miscompares++; $display("FAIL b2b_req2: got %b expected 1", mem_read_req); end
        mem_read_ack = 1'b1; mem_read_data = 32'h5A5A5A5A;
        @(posedge clock); #1;
        mem_read_ack = 1'b0;
        vectors++;
        if (reg_write !== 1'b1 || write_data !== 32'h5A5A5A5A) begin
            miscompares++; $display("FAIL b2b_wb2: got we %b data %h expected 1/5a5a5a5a", reg_write, write_data);
        end
        @(posedge clock); #1;
        vectors++;
        if (load_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_end: got %b expected 1", load_ready); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_byte_loads();
        test_half_loads();
        test_timeout();
        test_misalign();
        test_reset_mid();
        test_ack_outside_req();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
